// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC, req/ready imem fetch, F/D register and AdEL detection
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] F_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic        D_valid,
    output logic        D_excAdEL
);
    typedef enum logic {FETCH, HELD} state_t;
    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, r_hold, r_dpc, r_dinstr, w_instr;
    logic        r_dvalid, r_dexc, w_bad, w_adv, w_bubble, w_hold_ld, w_exc;
    assign w_bad     = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);
    assign imem_req  = (r_state == FETCH) && !w_bad && !reset;
    assign imem_addr = r_pc;
    assign F_PC      = r_pc;
    assign D_PC      = r_dpc;
    assign D_Instr   = r_dinstr;
    assign D_valid   = r_dvalid;
    assign D_excAdEL = r_dexc;
    always_comb begin
        w_state_nx = r_state;
        w_adv      = 1'b0;
        w_bubble   = 1'b0;
        w_hold_ld  = 1'b0;
        w_exc      = 1'b0;
        w_instr    = 32'h0;
        if (r_state == HELD) begin
            if (!stall) begin
                w_adv      = 1'b1;
                w_instr    = r_hold;
                w_state_nx = FETCH;
            end
        end else if (w_bad) begin
            w_adv = !stall;
            w_exc = 1'b1;
        end else if (imem_ready) begin
            // a word returned under stall is parked so it is captured exactly once
            w_hold_ld  = stall;
            w_state_nx = stall ? HELD : FETCH;
            w_adv      = !stall;
            w_instr    = imem_rdata;
        end else begin
            w_bubble = !stall;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_hold   <= 32'h0;
            r_dpc    <= 32'h0;
            r_dinstr <= 32'h0;
            r_dvalid <= 1'b0;
            r_dexc   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_hold_ld)
                r_hold <= imem_rdata;
            if (w_adv) begin
                r_pc     <= npc;
                r_dpc    <= r_pc;
                r_dinstr <= w_instr;
                r_dvalid <= 1'b1;
                r_dexc   <= w_exc;
            end else if (w_bubble) begin
                r_dinstr <= 32'h0;
                r_dvalid <= 1'b0;
                r_dexc   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, imem_ready;
    logic [31:0] npc, imem_rdata;
    logic [31:0] F_PC, imem_addr, D_PC, D_Instr;
    logic        imem_req, D_valid, D_excAdEL;
    int          n_vec = 0, n_err = 0, n_hs3008 = 0;
    logic        cnt_en = 1'b0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .npc(npc), .stall(stall),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .F_PC(F_PC), .imem_req(imem_req), .imem_addr(imem_addr),
        .D_PC(D_PC), .D_Instr(D_Instr), .D_valid(D_valid), .D_excAdEL(D_excAdEL)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (cnt_en && imem_req && imem_ready && imem_addr == 32'h3008)
            n_hs3008 <= n_hs3008 + 1;

    typedef struct {
        logic        rst, stl, rdy;
        logic [31:0] npc, rdata;
        logic        req;
        logic [31:0] fpc, dpc, di;
        logic        dv, de;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] np, input logic [31:0] dat);
        reset = r; stall = s; imem_ready = rd; npc = np; imem_rdata = dat;
    endtask

    task automatic check_d(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                           input logic [31:0] di, input logic dv, input logic de);
        chk({tag, " F_PC"}, F_PC, fpc);
        chk({tag, " D_PC"}, D_PC, dpc);
        chk({tag, " D_Instr"}, D_Instr, di);
        chk({tag, " D_valid"}, {31'h0, D_valid}, {31'h0, dv});
        chk({tag, " D_excAdEL"}, {31'h0, D_excAdEL}, {31'h0, de});
    endtask

    initial begin
        drive(1, 0, 0, 32'h3000, 32'h0);
        //        rst stl rdy npc          rdata          req  fpc       dpc       di            dv de
        vq.push_back('{1, 0, 1, 32'h3000, 32'h0000DEAD, 0, 32'h3000, 32'h0000, 32'h00000000, 0, 0}); // 0 reset
        vq.push_back('{0, 0, 1, 32'h3004, 32'hA0003000, 1, 32'h3004, 32'h3000, 32'hA0003000, 1, 0}); // 1 straight line
        vq.push_back('{0, 0, 1, 32'h3008, 32'hA0003004, 1, 32'h3008, 32'h3004, 32'hA0003004, 1, 0}); // 2
        vq.push_back('{0, 0, 1, 32'h300C, 32'hA0003008, 1, 32'h300C, 32'h3008, 32'hA0003008, 1, 0}); // 3
        vq.push_back('{1, 0, 1, 32'h3010, 32'h00001234, 0, 32'h3000, 32'h0000, 32'h00000000, 0, 0}); // 4 reset, ready ignored
        vq.push_back('{0, 0, 1, 32'h3004, 32'hA0003000, 1, 32'h3004, 32'h3000, 32'hA0003000, 1, 0}); // 5
        vq.push_back('{0, 0, 0, 32'h3008, 32'hBADBAD00, 1, 32'h3004, 32'h3000, 32'h00000000, 0, 0}); // 6 wait -> bubble
        vq.push_back('{0, 0, 1, 32'h3008, 32'hA0003004, 1, 32'h3008, 32'h3004, 32'hA0003004, 1, 0}); // 7
        vq.push_back('{0, 1, 1, 32'h300C, 32'h8C010004, 1, 32'h3008, 32'h3004, 32'hA0003004, 1, 0}); // 8 stall+ready
        vq.push_back('{0, 1, 1, 32'h300C, 32'hFFFFFFFF, 0, 32'h3008, 32'h3004, 32'hA0003004, 1, 0}); // 9 HELD
        vq.push_back('{0, 1, 0, 32'h300C, 32'hFFFFFFFF, 0, 32'h3008, 32'h3004, 32'hA0003004, 1, 0}); // 10 HELD
        vq.push_back('{0, 0, 0, 32'h300C, 32'hFFFFFFFF, 0, 32'h300C, 32'h3008, 32'h8C010004, 1, 0}); // 11 release
        vq.push_back('{0, 0, 1, 32'h3010, 32'h1000000C, 1, 32'h3010, 32'h300C, 32'h1000000C, 1, 0}); // 12 branch
        vq.push_back('{0, 0, 1, 32'h3040, 32'hA0003010, 1, 32'h3040, 32'h3010, 32'hA0003010, 1, 0}); // 13 delay slot
        vq.push_back('{0, 0, 1, 32'h3044, 32'hA0003040, 1, 32'h3044, 32'h3040, 32'hA0003040, 1, 0}); // 14 target
        vq.push_back('{0, 0, 1, 32'h3002, 32'hA0003044, 1, 32'h3002, 32'h3044, 32'hA0003044, 1, 0}); // 15
        vq.push_back('{0, 0, 1, 32'h7000, 32'hDEADBEEF, 0, 32'h7000, 32'h3002, 32'h00000000, 1, 1}); // 16 AdEL misaligned
        vq.push_back('{0, 1, 1, 32'h3000, 32'hDEADBEEF, 0, 32'h7000, 32'h3002, 32'h00000000, 1, 1}); // 17 bad+stall hold
        vq.push_back('{0, 0, 1, 32'h3000, 32'hDEADBEEF, 0, 32'h3000, 32'h7000, 32'h00000000, 1, 1}); // 18 AdEL high
        vq.push_back('{0, 1, 1, 32'h3004, 32'h11111111, 1, 32'h3000, 32'h7000, 32'h00000000, 1, 1}); // 19 enter HELD
        vq.push_back('{1, 1, 1, 32'h3004, 32'h33333333, 0, 32'h3000, 32'h0000, 32'h00000000, 0, 0}); // 20 reset in HELD
        vq.push_back('{0, 0, 1, 32'h3004, 32'h22222222, 1, 32'h3004, 32'h3000, 32'h22222222, 1, 0}); // 21 FETCH again
        @(negedge clk);
        foreach (vq[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vq[i].rst, vq[i].stl, vq[i].rdy, vq[i].npc, vq[i].rdata);
            cnt_en = (i >= 7 && i <= 11);
            #1;
            chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, vq[i].req});
            chk({tag, " imem_addr"}, imem_addr, F_PC);
            @(posedge clk);
            #1;
            check_d(tag, vq[i].fpc, vq[i].dpc, vq[i].di, vq[i].dv, vq[i].de);
            @(negedge clk);
        end
        cnt_en = 1'b0;
        chk("handshakes at 0x3008", n_hs3008, 1);
        // three wait cycles at 0x3004 give three bubbles with D_PC and address stable
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 32'h3008, 32'hBAD0BAD0);
            #1;
            chk($sformatf("w%0d imem_addr", k), imem_addr, 32'h3004);
            chk($sformatf("w%0d imem_req", k), {31'h0, imem_req}, 32'h1);
            @(posedge clk);
            #1;
            check_d($sformatf("w%0d", k), 32'h3004, 32'h3000, 32'h0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 1, 32'h3008, 32'hA0003004);
        @(posedge clk);
        #1;
        check_d("wdone", 32'h3008, 32'h3004, 32'hA0003004, 1, 0);
        // back-to-back zero-wait throughput
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pc;
            pc = 32'h3008 + 32'(k * 4);
            @(negedge clk);
            drive(0, 0, 1, pc + 32'h4, pc ^ 32'h5A5A0000);
            @(posedge clk);
            #1;
            check_d($sformatf("t%0d", k), pc + 32'h4, pc, pc ^ 32'h5A5A0000, 1, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
